adc_ddr_capture: RTL
====================

ADC_DDR_CAPTURE -- requirements
Module: adc_ddr_capture

Interface
REQ-001 Parameter NUM_CH, default 1: ADC channel count, legal range 1..4.
REQ-002 Parameter LANES, default 6: DDR lanes per channel; sample width W = 2*LANES.
REQ-003 Parameter TRAIN_PATTERN, default 12'hA5C, width W: ADC test word used for edge-order alignment.
REQ-004 Parameter LOCK_CNT, default 16: consecutive pattern matches required to lock a channel.
REQ-005 Parameter TRAIN_TIMEOUT, default 1024: cycles allowed for training before failure.
REQ-006 Parameter LEN_W, default 16: width of the capture length.
REQ-007 Port clk, input, 1: DCO-derived capture clock; sole clock, all logic on rising edge.
REQ-008 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 Port din_rise, input, NUM_CH*LANES: IDDR rising-edge outputs, channel c at bits [c*LANES +: LANES].
REQ-010 Port din_fall, input, NUM_CH*LANES: IDDR falling-edge outputs, same packing.
REQ-011 Port or_in, input, NUM_CH: per-channel overrange bit, sampled each cycle.
REQ-012 Port train_start, input, 1: single-cycle pulse starting alignment.
REQ-013 Port capture_start, input, 1: single-cycle pulse starting a capture.
REQ-014 Port capture_len, input, LEN_W: number of words to capture, sampled with capture_start.
REQ-015 Port m_data, output, NUM_CH*W: aligned samples, channel c at [c*W +: W].
REQ-016 Port m_or, output, NUM_CH: overrange bits aligned with m_data.
REQ-017 Port m_valid, output, 1 / m_ready, input, 1: output handshake.
REQ-018 Port status outputs, 1 each: train_done, train_fail, capture_busy, overflow; plus swap, NUM_CH: selected edge order per channel; or_sticky, NUM_CH.

Function
REQ-019 The assembler SHALL form per channel cand0 = {rise(k), fall(k)} and cand1 = {fall(k-1), rise(k)}, registering the previous fall half every cycle.
REQ-020 The aligned word SHALL be cand0 when swap[c]=0, cand1 when swap[c]=1, registered once (latency 1 from din).
REQ-021 The FSM SHALL have states IDLE, TRAIN, LOCKED, FAIL, CAPTURE; reset state IDLE.
REQ-022 IDLE/LOCKED/FAIL -> TRAIN on train_start; TRAIN clears swap, match counters, timeout counter, train_done, train_fail.
REQ-023 In TRAIN, each unlocked channel SHALL keep two saturating counters of consecutive cycles cand0/cand1 equals TRAIN_PATTERN, resetting a counter to 0 on mismatch.
REQ-024 The first counter to reach LOCK_CNT SHALL lock the channel and set swap[c] to that candidate; if both reach it the same cycle, swap[c]=0.
REQ-025 When all channels are locked, TRAIN -> LOCKED and train_done=1 the next cycle.
REQ-026 If the timeout counter reaches TRAIN_TIMEOUT before full lock, TRAIN -> FAIL, train_fail=1, swap retains partial results.
REQ-027 capture_start SHALL be honoured only in LOCKED; elsewhere ignored; train_start SHALL be ignored in CAPTURE.
REQ-028 On honoured capture_start: latch capture_len, clear overflow and or_sticky; if capture_len=0 stay LOCKED, else -> CAPTURE with capture_busy=1.
REQ-029 In CAPTURE, each aligned word SHALL be offered once; first word is the one aligned in the cycle after capture_start; latency din -> m_data is 2 cycles.
REQ-030 m_data/m_or SHALL hold stable while m_valid=1 and m_ready=0; transfer occurs when both high.
REQ-031 If a new word arrives while the held word is unaccepted, the new word SHALL be dropped, overflow set (sticky), and it SHALL still count toward capture_len.
REQ-032 After capture_len words are produced, CAPTURE -> LOCKED, capture_busy=0 the same cycle the last word is offered; m_valid stays until that word is accepted.
REQ-033 or_sticky[c] SHALL set whenever a captured word's overrange bit is 1.

Reset
REQ-034 With rst_n=0 at a clock edge: state IDLE, m_valid=0, m_data=0, m_or=0, swap=0, all counters 0, train_done, train_fail, capture_busy, overflow, or_sticky all 0.
REQ-035 Reset SHALL take precedence over all inputs, including mid-training and mid-capture.

Verification
REQ-036 NUM_CH=1, din producing cand0=12'hA5C for 16 cycles after train_start -> swap=0, train_done=1, state LOCKED.
REQ-037 NUM_CH=2, ch1 pattern only on cand1 -> swap=2'b10, train_done=1 after 16 matching cycles.
REQ-038 Pattern absent for 1024 cycles -> train_fail=1, train_done=0, capture_start ignored.
REQ-039 LOCKED, capture_len=4, m_ready=1, ramp input -> exactly 4 words in order, 2-cycle latency, capture_busy falls, overflow=0.
REQ-040 capture_len=8, m_ready=0 for 3 cycles -> first word held stable, 3 words dropped, overflow=1, 8 words counted.
REQ-041 rst_n=0 mid-capture -> next cycle all outputs at reset values, capture_start ignored until retrained.

Source files
------------

// File: rtl/adc_ddr_capture.sv
// ADC DDR capture: rebuilds samples from IDDR rise/fall halves, trains edge order per channel, then streams a fixed-length capture.
// Latency din->m_data 2 cycles; if m_data is held by m_ready=0, newer words are dropped and counted (overflow flag).
module adc_ddr_capture #(
    parameter int                 NUM_CH        = 1,
    parameter int                 LANES         = 6,
    parameter logic [2*LANES-1:0] TRAIN_PATTERN = 12'hA5C,
    parameter int                 LOCK_CNT      = 16,
    parameter int                 TRAIN_TIMEOUT = 1024,
    parameter int                 LEN_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*LANES-1:0]   din_rise,
    input  logic [NUM_CH*LANES-1:0]   din_fall,
    input  logic [NUM_CH-1:0]         or_in,
    input  logic                      train_start,
    input  logic                      capture_start,
    input  logic [LEN_W-1:0]          capture_len,
    output logic [NUM_CH*2*LANES-1:0] m_data,
    output logic [NUM_CH-1:0]         m_or,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      train_done,
    output logic                      train_fail,
    output logic                      capture_busy,
    output logic                      overflow,
    output logic [NUM_CH-1:0]         swap,
    output logic [NUM_CH-1:0]         or_sticky
);

    localparam int W  = 2 * LANES;
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int TW = $clog2(TRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] LOCK_V = CW'(LOCK_CNT);
    localparam logic [TW-1:0] TMO_V  = TW'(TRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRAIN   = 3'd1,
        S_LOCKED  = 3'd2,
        S_FAIL    = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [NUM_CH*LANES-1:0]    prev_fall_q, prev_fall_d;
    logic [NUM_CH*W-1:0]        aligned_q, aligned_d;
    logic [NUM_CH-1:0]          or_al_q, or_al_d;
    logic [NUM_CH-1:0][CW-1:0]  m0_q, m0_d, m1_q, m1_d;
    logic [NUM_CH-1:0]          locked_q, locked_d;
    logic [NUM_CH-1:0]          swap_q, swap_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [LEN_W-1:0]           len_q, len_d, cnt_q, cnt_d;
    logic [NUM_CH*W-1:0]        m_data_q, m_data_d;
    logic [NUM_CH-1:0]          m_or_q, m_or_d;
    logic                       m_valid_q, m_valid_d;
    logic                       done_q, done_d;
    logic                       fail_q, fail_d;
    logic                       busy_q, busy_d;
    logic                       ovf_q, ovf_d;
    logic [NUM_CH-1:0]          or_sticky_q, or_sticky_d;
    logic [NUM_CH-1:0][W-1:0]   cand0, cand1;
    logic                       go_train;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == LOCK_V) ? v : v + CW'(1);
    endfunction

    // cand1 pairs last cycle's fall half with this cycle's rise half
    always_comb begin
        cand0       = '0;
        cand1       = '0;
        aligned_d   = '0;
        prev_fall_d = din_fall;
        or_al_d     = or_in;
        for (int c = 0; c < NUM_CH; c++) begin
            cand0[c] = {din_rise[c*LANES +: LANES], din_fall[c*LANES +: LANES]};
            cand1[c] = {prev_fall_q[c*LANES +: LANES], din_rise[c*LANES +: LANES]};
            aligned_d[c*W +: W] = swap_q[c] ? cand1[c] : cand0[c];
        end
    end

    always_comb begin
        state_d     = state_q;
        m0_d        = m0_q;
        m1_d        = m1_q;
        locked_d    = locked_q;
        swap_d      = swap_q;
        tmo_d       = tmo_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        m_data_d    = m_data_q;
        m_or_d      = m_or_q;
        m_valid_d   = m_valid_q;
        done_d      = done_q;
        fail_d      = fail_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        or_sticky_d = or_sticky_q;
        go_train    = train_start &&
                      (state_q == S_IDLE || state_q == S_LOCKED || state_q == S_FAIL);

        if (m_valid_q && m_ready)
            m_valid_d = 1'b0;

        case (state_q)
            S_TRAIN: begin
                tmo_d = tmo_q + TW'(1);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!locked_q[c]) begin
                        m0_d[c] = (cand0[c] == TRAIN_PATTERN) ? sat_inc(m0_q[c]) : '0;
                        m1_d[c] = (cand1[c] == TRAIN_PATTERN) ? sat_inc(m1_q[c]) : '0;
                        // A tie goes to the natural rise-first order
                        if (m0_d[c] == LOCK_V || m1_d[c] == LOCK_V) begin
                            locked_d[c] = 1'b1;
                            swap_d[c]   = (m0_d[c] != LOCK_V);
                        end
                    end
                end
                if (&locked_d) begin
                    state_d = S_LOCKED;
                    done_d  = 1'b1;
                end else if (tmo_d == TMO_V) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                end
            end
            S_LOCKED: begin
                if (!train_start && capture_start) begin
                    len_d       = capture_len;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    or_sticky_d = '0;
                    if (capture_len != '0) begin
                        state_d = S_CAPTURE;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                cnt_d       = cnt_q + LEN_W'(1);
                or_sticky_d = or_sticky_q | or_al_q;
                // Dropped words still count toward the requested length
                if (!m_valid_q || m_ready) begin
                    m_data_d  = aligned_q;
                    m_or_d    = or_al_q;
                    m_valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
                if (cnt_d == len_q) begin
                    state_d = S_LOCKED;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase

        if (go_train) begin
            state_d  = S_TRAIN;
            swap_d   = '0;
            m0_d     = '0;
            m1_d     = '0;
            locked_d = '0;
            tmo_d    = '0;
            done_d   = 1'b0;
            fail_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prev_fall_q <= '0;
            aligned_q   <= '0;
            or_al_q     <= '0;
            m0_q        <= '0;
            m1_q        <= '0;
            locked_q    <= '0;
            swap_q      <= '0;
            tmo_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            m_data_q    <= '0;
            m_or_q      <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            or_sticky_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_fall_q <= prev_fall_d;
            aligned_q   <= aligned_d;
            or_al_q     <= or_al_d;
            m0_q        <= m0_d;
            m1_q        <= m1_d;
            locked_q    <= locked_d;
            swap_q      <= swap_d;
            tmo_q       <= tmo_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            m_data_q    <= m_data_d;
            m_or_q      <= m_or_d;
            m_valid_q   <= m_valid_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            or_sticky_q <= or_sticky_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_or         = m_or_q;
    assign m_valid      = m_valid_q;
    assign train_done   = done_q;
    assign train_fail   = fail_q;
    assign capture_busy = busy_q;
    assign overflow     = ovf_q;
    assign swap         = swap_q;
    assign or_sticky    = or_sticky_q;

endmodule
